// File: rtl/bram_rom_arbiter.sv
// Round-robin arbiter sharing one 1-cycle-latency block ROM between fetch (0) and load (1).
// Optional performance counters are built when BRAM_ROM_ARB_PERF_EN is defined.
module bram_rom_arbiter #(
  parameter int DW = 32,
  parameter int AW = 10
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [1:0]      i_req_valid,
  output logic [1:0]      o_req_ready,
  input  logic [2*AW-1:0] i_req_addr,
  output logic [1:0]      o_rsp_valid,
  input  logic [1:0]      i_rsp_ready,
  output logic [DW-1:0]   o_rsp_data,
  output logic            o_rom_en,
  output logic [AW-1:0]   o_rom_addr,
  input  logic [DW-1:0]   i_rom_data,
  output logic [31:0]     o_perf_grant0,
  output logic [31:0]     o_perf_grant1,
  output logic [31:0]     o_perf_conflict,
  output logic [31:0]     o_perf_stall
);

  if (DW < 1) begin : g_dw_chk
    $error("bram_rom_arbiter: DW must be >= 1");
  end
  if (AW < 1) begin : g_aw_chk
    $error("bram_rom_arbiter: AW must be >= 1");
  end

  logic r_pend, r_owner, r_last;
  logic pend_d, owner_d, last_d;
  logic free, gnt_vld, gnt_idx;

  // Reset gating keeps every combinational output at 0 while i_rst_n is low.
  always_comb begin
    free    = i_rst_n & (~r_pend | i_rsp_ready[r_owner]);
    gnt_vld = free & (|i_req_valid);
    gnt_idx = 1'b0;
    case (i_req_valid)
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ~r_last;
      default: gnt_idx = 1'b0;
    endcase
  end

  always_comb begin
    o_req_ready = 2'b00;
    o_rom_en    = gnt_vld;
    o_rom_addr  = '0;
    if (gnt_vld) begin
      o_req_ready = gnt_idx ? 2'b10 : 2'b01;
      o_rom_addr  = gnt_idx ? i_req_addr[2*AW-1:AW] : i_req_addr[AW-1:0];
    end
    o_rsp_valid = 2'b00;
    if (r_pend) begin
      o_rsp_valid = r_owner ? 2'b10 : 2'b01;
    end
    // The ROM output register is the response holding register.
    o_rsp_data = i_rst_n ? i_rom_data : '0;
  end

  always_comb begin
    pend_d  = r_pend;
    owner_d = r_owner;
    last_d  = r_last;
    if (gnt_vld) begin
      pend_d  = 1'b1;
      owner_d = gnt_idx;
      last_d  = gnt_idx;
    end else if (r_pend && i_rsp_ready[r_owner]) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend  <= 1'b0;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      r_pend  <= pend_d;
      r_owner <= owner_d;
      r_last  <= last_d;
    end
  end

`ifdef BRAM_ROM_ARB_PERF_EN
  logic [31:0] r_grant0, r_grant1, r_conflict, r_stall;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_grant0   <= 32'h0;
      r_grant1   <= 32'h0;
      r_conflict <= 32'h0;
      r_stall    <= 32'h0;
    end else begin
      if (gnt_vld && !gnt_idx) r_grant0 <= r_grant0 + 32'd1;
      if (gnt_vld && gnt_idx) r_grant1 <= r_grant1 + 32'd1;
      if (free && (&i_req_valid)) r_conflict <= r_conflict + 32'd1;
      if (r_pend && !i_rsp_ready[r_owner]) r_stall <= r_stall + 32'd1;
    end
  end

  assign o_perf_grant0   = r_grant0;
  assign o_perf_grant1   = r_grant1;
  assign o_perf_conflict = r_conflict;
  assign o_perf_stall    = r_stall;
`else
  assign o_perf_grant0   = 32'h0;
  assign o_perf_grant1   = 32'h0;
  assign o_perf_conflict = 32'h0;
  assign o_perf_stall    = 32'h0;
`endif

endmodule

// File: tb/tb_bram_rom_arbiter.sv
// Self-checking bench for bram_rom_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of the arbiter and a behavioural ROM.
`timescale 1ns/1ps
module tb_bram_rom_arbiter;
  localparam int DW = 32;
  localparam int AW = 10;
`ifdef BRAM_ROM_ARB_PERF_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  logic            i_clk = 1'b0;
  logic            i_rst_n = 1'b0;
  logic [1:0]      i_req_valid = '0;
  logic [1:0]      o_req_ready;
  logic [2*AW-1:0] i_req_addr = '0;
  logic [1:0]      o_rsp_valid;
  logic [1:0]      i_rsp_ready = '0;
  logic [DW-1:0]   o_rsp_data;
  logic            o_rom_en;
  logic [AW-1:0]   o_rom_addr;
  logic [DW-1:0]   i_rom_data;
  logic [31:0]     o_perf_grant0, o_perf_grant1, o_perf_conflict, o_perf_stall;

  bram_rom_arbiter #(.DW(DW), .AW(AW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_addr(i_req_addr),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_data(o_rsp_data),
    .o_rom_en(o_rom_en), .o_rom_addr(o_rom_addr), .i_rom_data(i_rom_data),
    .o_perf_grant0(o_perf_grant0), .o_perf_grant1(o_perf_grant1),
    .o_perf_conflict(o_perf_conflict), .o_perf_stall(o_perf_stall)
  );

  always #5 i_clk = ~i_clk;

  // Behavioural single-port ROM with a registered output.
  logic [DW-1:0] mem [1024];
  logic [DW-1:0] rom_q = 32'hA5A5_5A5A;
  always @(posedge i_clk) if (o_rom_en) rom_q <= mem[o_rom_addr];
  assign i_rom_data = rom_q;

  int n_cmp = 0;
  int n_err = 0;

  // Transaction-level model: one outstanding read at most, winner alternates under contention.
  bit            m_pend;
  int            m_owner;
  logic [AW-1:0] m_addr;
  int            m_last_win;
  int unsigned   m_g0, m_g1, m_conf, m_stall;
  bit            e_free;
  int            e_win;
  logic [1:0]    e_ready, e_rsp_valid;
  logic          e_en;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;

  task automatic model_reset();
    m_pend = 0; m_owner = 0; m_addr = '0; m_last_win = 1;
    m_g0 = 0; m_g1 = 0; m_conf = 0; m_stall = 0; e_win = -1;
  endtask

  task automatic model_eval();
    e_free = !m_pend || i_rsp_ready[m_owner];
    e_win  = -1;
    if (e_free) begin
      if (i_req_valid == 2'b11) e_win = 1 - m_last_win;
      else if (i_req_valid[0])  e_win = 0;
      else if (i_req_valid[1])  e_win = 1;
    end
    e_ready     = (e_win < 0) ? 2'b00 : 2'(1 << e_win);
    e_en        = (e_win >= 0);
    e_addr      = (e_win < 0) ? '0 : i_req_addr[e_win*AW +: AW];
    e_rsp_valid = m_pend ? 2'(1 << m_owner) : 2'b00;
    e_data      = mem[m_addr];
  endtask

  task automatic next_cycle();
    if (i_req_valid == 2'b11 && e_free) m_conf++;
    if (m_pend && !i_rsp_ready[m_owner]) m_stall++;
    if (e_win >= 0) begin
      m_pend = 1; m_owner = e_win; m_addr = e_addr; m_last_win = e_win;
      if (e_win == 0) m_g0++; else m_g1++;
    end else if (m_pend && i_rsp_ready[m_owner]) begin
      m_pend = 0;
    end
    @(posedge i_clk); #1;
  endtask

  task automatic test_reset();
    i_req_valid = 2'b11; i_rsp_ready = 2'b11; i_req_addr = {10'h2AA, 10'h155};
    @(negedge i_clk);
    n_cmp++; if ({o_req_ready, o_rom_en, o_rom_addr, o_rsp_valid} !== '0) begin
      n_err++; $display("FAIL reset_ctrl: got rdy=%b en=%b addr=%h rv=%b, want all 0",
                        o_req_ready, o_rom_en, o_rom_addr, o_rsp_valid);
    end
    n_cmp++; if (o_rsp_data !== '0) begin
      n_err++; $display("FAIL reset_data: got %h want 0", o_rsp_data);
    end
    n_cmp++; if ({o_perf_grant0, o_perf_grant1, o_perf_conflict, o_perf_stall} !== '0) begin
      n_err++; $display("FAIL reset_perf: got %h %h %h %h want 0", o_perf_grant0,
                        o_perf_grant1, o_perf_conflict, o_perf_stall);
    end
    @(posedge i_clk); #1;
    i_rst_n = 1'b1; i_req_valid = 2'b00;
    model_reset();
  endtask

  task automatic test_contention();
    i_req_valid = 2'b11; i_rsp_ready = 2'b11; i_req_addr = {10'h020, 10'h010};
    for (int i = 0; i < 8; i++) begin
      @(negedge i_clk); model_eval();
      n_cmp++; if (o_req_ready !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        n_err++; $display("FAIL contention_grant[%0d]: got %b want %b", i, o_req_ready,
                          (i % 2 == 0) ? 2'b01 : 2'b10);
      end
      n_cmp++; if (o_rsp_valid !== e_rsp_valid || (m_pend && o_rsp_data !== e_data)) begin
        n_err++; $display("FAIL contention_rsp[%0d]: got %b/%h want %b/%h", i, o_rsp_valid,
                          o_rsp_data, e_rsp_valid, e_data);
      end
      next_cycle();
    end
    i_req_valid = 2'b00;
    @(negedge i_clk); model_eval();
    n_cmp++; if (o_rsp_valid !== 2'b10 || o_rsp_data !== mem[10'h020]) begin
      n_err++; $display("FAIL contention_last_rsp: got %b/%h want 10/%h", o_rsp_valid,
                        o_rsp_data, mem[10'h020]);
    end
    n_cmp++; if (o_perf_grant0 !== (PerfEn ? 32'd4 : 32'd0) ||
                 o_perf_grant1 !== (PerfEn ? 32'd4 : 32'd0) ||
                 o_perf_conflict !== (PerfEn ? 32'd8 : 32'd0) || o_perf_stall !== 32'd0) begin
      n_err++; $display("FAIL contention_perf: got %0d %0d %0d %0d want %0d %0d %0d 0",
                        o_perf_grant0, o_perf_grant1, o_perf_conflict, o_perf_stall,
                        PerfEn ? 4 : 0, PerfEn ? 4 : 0, PerfEn ? 8 : 0);
    end
    next_cycle();
  endtask

  task automatic test_single();
    i_req_valid = 2'b01; i_req_addr = {10'h000, 10'h005}; i_rsp_ready = 2'b11;
    @(negedge i_clk); model_eval();
    n_cmp++; if (o_rom_en !== 1'b1 || o_rom_addr !== 10'h005 || o_req_ready !== 2'b01) begin
      n_err++; $display("FAIL single_accept: got en=%b addr=%h rdy=%b want 1/005/01",
                        o_rom_en, o_rom_addr, o_req_ready);
    end
    next_cycle();
    i_req_valid = 2'b00;
    @(negedge i_clk); model_eval();
    n_cmp++; if (o_rsp_valid !== 2'b01 || o_rsp_data !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL single_rsp: got %b/%h want 01/deadbeef", o_rsp_valid,
                        o_rsp_data);
    end
    next_cycle();
  endtask

  task automatic test_stall();
    i_req_valid = 2'b10; i_req_addr = {10'h3FF, 10'h123}; i_rsp_ready = 2'b11;
    @(negedge i_clk); model_eval();
    n_cmp++; if (o_req_ready !== 2'b10 || o_rom_addr !== 10'h3FF) begin
      n_err++; $display("FAIL stall_accept: got rdy=%b addr=%h want 10/3ff", o_req_ready,
                        o_rom_addr);
    end
    next_cycle();
    i_req_valid = 2'b01; i_rsp_ready = 2'b01;
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk); model_eval();
      n_cmp++; if (o_rom_en !== 1'b0 || o_req_ready !== 2'b00 || o_rsp_valid !== 2'b10 ||
                   o_rsp_data !== mem[10'h3FF]) begin
        n_err++; $display("FAIL stall_hold[%0d]: got en=%b rdy=%b rv=%b d=%h want 0/00/10/%h",
                          i, o_rom_en, o_req_ready, o_rsp_valid, o_rsp_data, mem[10'h3FF]);
      end
      next_cycle();
    end
    i_rsp_ready = 2'b11;
    @(negedge i_clk); model_eval();
    n_cmp++; if (o_req_ready !== 2'b01 || o_rom_addr !== 10'h123 || o_rsp_valid !== 2'b10) begin
      n_err++; $display("FAIL stall_release: got rdy=%b addr=%h rv=%b want 01/123/10",
                        o_req_ready, o_rom_addr, o_rsp_valid);
    end
    next_cycle();
    i_req_valid = 2'b00;
    @(negedge i_clk); model_eval();
    n_cmp++; if (o_rsp_valid !== 2'b01 || o_rsp_data !== mem[10'h123]) begin
      n_err++; $display("FAIL stall_next_rsp: got %b/%h want 01/%h", o_rsp_valid, o_rsp_data,
                        mem[10'h123]);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] addrs [3];
    addrs[0] = 10'h3FE; addrs[1] = 10'h3FF; addrs[2] = 10'h000;
    i_rsp_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      i_req_valid = (i < 3) ? 2'b01 : 2'b00;
      if (i < 3) i_req_addr[AW-1:0] = addrs[i];
      @(negedge i_clk); model_eval();
      if (i < 3) begin
        n_cmp++; if (o_req_ready !== 2'b01 || o_rom_addr !== addrs[i]) begin
          n_err++; $display("FAIL b2b_accept[%0d]: got rdy=%b addr=%h want 01/%h", i,
                            o_req_ready, o_rom_addr, addrs[i]);
        end
      end
      if (i > 0) begin
        n_cmp++; if (o_rsp_valid !== 2'b01 || o_rsp_data !== mem[addrs[i-1]]) begin
          n_err++; $display("FAIL b2b_rsp[%0d]: got %b/%h want 01/%h", i, o_rsp_valid,
                            o_rsp_data, mem[addrs[i-1]]);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (!i_req_valid[k] || e_win == k) begin
          i_req_valid[k] = ($urandom_range(0, 2) != 0);
          i_req_addr[k*AW +: AW] = AW'($urandom);
        end
        i_rsp_ready[k] = ($urandom_range(0, 3) != 0);
      end
      @(negedge i_clk); model_eval();
      n_cmp++; if (o_req_ready !== e_ready || o_rom_en !== e_en || o_rom_addr !== e_addr) begin
        n_err++; $display("FAIL rand_req[%0d]: got rdy=%b en=%b addr=%h want %b/%b/%h", c,
                          o_req_ready, o_rom_en, o_rom_addr, e_ready, e_en, e_addr);
      end
      n_cmp++; if (o_rsp_valid !== e_rsp_valid || (m_pend && o_rsp_data !== e_data)) begin
        n_err++; $display("FAIL rand_rsp[%0d]: got %b/%h want %b/%h", c, o_rsp_valid,
                          o_rsp_data, e_rsp_valid, e_data);
      end
      next_cycle();
    end
    i_req_valid = 2'b00;
    @(negedge i_clk); model_eval();
    n_cmp++; if (o_perf_grant0 !== (PerfEn ? 32'(m_g0) : 32'd0) ||
                 o_perf_grant1 !== (PerfEn ? 32'(m_g1) : 32'd0) ||
                 o_perf_conflict !== (PerfEn ? 32'(m_conf) : 32'd0) ||
                 o_perf_stall !== (PerfEn ? 32'(m_stall) : 32'd0)) begin
      n_err++; $display("FAIL rand_perf: got %0d %0d %0d %0d want %0d %0d %0d %0d",
                        o_perf_grant0, o_perf_grant1, o_perf_conflict, o_perf_stall,
                        PerfEn ? m_g0 : 0, PerfEn ? m_g1 : 0, PerfEn ? m_conf : 0,
                        PerfEn ? m_stall : 0);
    end
    next_cycle();
  endtask

  task automatic test_reset_midstream();
    i_req_valid = 2'b01; i_req_addr = {10'h077, 10'h055}; i_rsp_ready = 2'b11;
    @(negedge i_clk); model_eval(); next_cycle();
    i_req_valid = 2'b11; i_rsp_ready = 2'b00;
    @(negedge i_clk); model_eval();
    n_cmp++; if (o_rsp_valid !== 2'b01) begin
      n_err++; $display("FAIL midrst_pending: got %b want 01", o_rsp_valid);
    end
    next_cycle();
    i_rst_n = 1'b0;
    #1;
    n_cmp++; if ({o_req_ready, o_rom_en, o_rom_addr, o_rsp_valid, o_rsp_data} !== '0) begin
      n_err++; $display("FAIL midrst_outputs: got rdy=%b en=%b addr=%h rv=%b d=%h want all 0",
                        o_req_ready, o_rom_en, o_rom_addr, o_rsp_valid, o_rsp_data);
    end
    n_cmp++; if ({o_perf_grant0, o_perf_grant1, o_perf_conflict, o_perf_stall} !== '0) begin
      n_err++; $display("FAIL midrst_perf: got %h %h %h %h want 0", o_perf_grant0,
                        o_perf_grant1, o_perf_conflict, o_perf_stall);
    end
    model_reset();
    @(posedge i_clk); #1;
    i_rst_n = 1'b1; i_rsp_ready = 2'b11;
    @(negedge i_clk); model_eval();
    n_cmp++; if (o_rsp_valid !== 2'b00 || o_req_ready !== 2'b01) begin
      n_err++; $display("FAIL midrst_after: got rv=%b rdy=%b want 00/01", o_rsp_valid,
                        o_req_ready);
    end
    next_cycle();
    i_req_valid = 2'b00;
    @(negedge i_clk); model_eval();
    n_cmp++; if (o_rsp_valid !== 2'b01 || o_rsp_data !== mem[10'h055]) begin
      n_err++; $display("FAIL midrst_first_rsp: got %b/%h want 01/%h", o_rsp_valid,
                        o_rsp_data, mem[10'h055]);
    end
    next_cycle();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[5] = 32'hDEADBEEF;
    model_reset();
    test_reset();
    test_contention();
    test_single();
    test_stall();
    test_back_to_back();
    test_random();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bram_rom_arbiter.md
Name: bram_rom_arbiter

Overview:
- Shares one single-port, 1-cycle-latency block ROM between two read requesters: requester 0 is instruction fetch, requester 1 is data/constant load.
- Arbitration is round-robin with valid/ready handshakes on both the request and response sides.
- Drives the ROM's enable and address directly.
- Uses the ROM's output register as the response holding register, so no data buffer is needed.

Parameters:
- DW, 32, data width; must match the ROM. Value < 1 is an elaboration $error.
- AW, 10, word-address width; must match the ROM. Value < 1 is an elaboration $error.

Ports:
- i_clk  input  1  Clock; all logic on the rising edge.
- i_rst_n  input  1  Reset, asynchronous, active-low.
- i_req_valid  input  2  Per-requester request valid; bit k belongs to requester k.
- o_req_ready  output  2  Per-requester request accepted this cycle.
- i_req_addr  input  2*AW  Word addresses; requester k uses bits [k*AW +: AW].
- o_rsp_valid  output  2  One-hot response valid; selects the owner of o_rsp_data.
- i_rsp_ready  input  2  Per-requester response accept.
- o_rsp_data  output  DW  Response data; equals i_rom_data.
- o_rom_en  output  1  ROM read enable.
- o_rom_addr  output  AW  ROM address.
- i_rom_data  input  DW  ROM registered output.
- o_perf_grant0  output  32  Optional counter, see Optional Feature.
- o_perf_grant1  output  32  Optional counter, see Optional Feature.
- o_perf_conflict  output  32  Optional counter, see Optional Feature.
- o_perf_stall  output  32  Optional counter, see Optional Feature.

Behaviour:
- State registers:
  - r_pend: a response is outstanding.
  - r_owner: requester of the outstanding response.
  - r_last: last granted requester, for round-robin.
- Reset (async assert, sync-safe deassert): r_pend=0, r_owner=0, r_last=1, so requester 0 wins the first conflict. All outputs are 0 during reset, including o_rom_en, o_rom_addr and the counters.
- Free condition: free = !r_pend | (i_rsp_ready[r_owner] & r_pend).
- Grant (combinational):
  - Only requester 0 valid: grant 0.
  - Only requester 1 valid: grant 1.
  - Both valid: grant !r_last.
  - No grant when !free or neither valid.
- o_req_ready[k] = free & grant==k. Ready is never asserted to both requesters in the same cycle.
- Accept (valid & ready) in cycle T:
  - o_rom_en=1 and o_rom_addr=i_req_addr[grant] in cycle T, combinationally.
  - At the edge ending T: r_pend<=1, r_owner<=grant, r_last<=grant.
- Response in cycle T+1: o_rsp_valid[r_owner]=1, o_rsp_data=i_rom_data. Latency is exactly 1 cycle from accept to response valid.
- Stall: while r_pend and !i_rsp_ready[r_owner], o_rom_en=0. The ROM register holds its value, so o_rsp_data stays stable until accepted.
- Response accepted with no new accept in the same cycle: r_pend<=0 at the edge.
- Back-to-back: a response accept and a new request accept may occur in the same cycle. Throughput is 1 read/cycle. r_pend stays 1 and r_owner updates.
- Idle: o_rom_en=0. o_rom_addr=0 when no grant; it is a don't-care to the ROM but is specified as 0 for the bench.
- Requester protocol: once i_req_valid[k] is raised it holds, with a stable address, until accepted. Bench assertion only; not checked in RTL.
- Round-robin fairness: under continuous contention, grants alternate 0,1,0,1 with no starvation.
- Reset mid-operation: any outstanding response is dropped with no o_rsp_valid. The ROM's own reset is driven separately.
- o_rsp_valid is never asserted to both requesters; at most one bit is set.

Optional Feature:
- Macro: BRAM_ROM_ARB_PERF_EN.
- When defined, four 32-bit free-running, wrapping counters, cleared by reset:
  - o_perf_grant0: +1 per accept from requester 0.
  - o_perf_grant1: +1 per accept from requester 1.
  - o_perf_conflict: +1 per cycle where both requests are valid and free=1.
  - o_perf_stall: +1 per cycle where r_pend=1 and the owner's i_rsp_ready=0.
- When undefined: the ports remain and are tied to 32'h0, and no counter flops are synthesized.

Test Plan:
- Reset: assert i_rst_n=0 mid-stream with a pending response -> all outputs 0 immediately; after release, no stale o_rsp_valid appears and the first conflict grants requester 0.
- Single read: requester 0 requests address 0x005 with ROM word 0xDEADBEEF and i_rsp_ready=1 -> o_rom_en=1 and o_rom_addr=0x005 in the accept cycle; o_rsp_valid=2'b01 and o_rsp_data=0xDEADBEEF on the next cycle.
- Contention: both requesters valid continuously, addresses 0x010 and 0x020, both ready -> grants alternate 0,1,0,1 over 8 cycles; one response per cycle with the correct owner/data pairing.
- Response stall: requester 1 reads 0x3FF and holds i_rsp_ready[1]=0 for 4 cycles while requester 0 is valid -> o_rom_en=0, o_req_ready=0 and o_rsp_data stable for 4 cycles; requester 0 is granted in the cycle i_rsp_ready[1] rises.
- Back-to-back with wrap: requester 0 streams addresses 0x3FE, 0x3FF, 0x000 -> 3 responses in 3 consecutive cycles with matching data.
- With BRAM_ROM_ARB_PERF_EN, after the contention test -> o_perf_grant0=4, o_perf_grant1=4, o_perf_conflict=8; without the macro, all counters read 0.
